// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-memory port arbiter and the SPI
// programming front end that talks to it.
package imem_arb_pkg;

  localparam int DEF_ADDR_WIDTH      = 4;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_RST_HOLD_CYCLES = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    PROG    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Command bytes decoded by spi_wrapper
  localparam logic [7:0] LOAD_LL     = 8'hC0;
  localparam logic [7:0] LOAD_LH     = 8'hC1;
  localparam logic [7:0] LOAD_HL     = 8'hC2;
  localparam logic [7:0] LOAD_HH     = 8'hC3;
  localparam logic [7:0] LOAD_ADDR   = 8'hC4;
  localparam logic [7:0] WRITE_INSTR = 8'hC5;
  localparam logic [7:0] MODE_RUN    = 8'hC6;
  localparam logic [7:0] MODE_BOOT   = 8'hC7;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Single-port instruction memory bus: the arbiter is the master, the RAM the slave.
interface imem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_oe;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_oe,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_oe,
    input  mem_wr_data,
    output mem_rd_data
  );

endinterface

// File: rtl/imem_port_arbiter_wr_stage.sv
// Single-entry registered write stage: a write accepted this cycle drives the RAM
// next cycle. Only the valid bit is reset; address/data are qualified by it.
module imem_wr_stage #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= load_i;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      addr_q <= addr_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction RAM port between CPU fetch and the SPI programmer, and
// sequences CPU reset around programming sessions.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_req,
  input  logic                  prog_wr_valid,
  output logic                  prog_wr_ready,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  cpu_fetch_req,
  input  logic [ADDR_WIDTH-1:0] cpu_fetch_addr,
  output logic                  cpu_fetch_valid,
  output logic [DATA_WIDTH-1:0] cpu_fetch_data,
  output logic                  cpu_stall,
  output logic                  cpu_rst_n,
  imem_port_arbiter_if.master   mem,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  busy
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_vld_q;

  logic                  fetch_issue;
  logic                  wr_accept;
  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign fetch_issue = (state_q == RUN) && cpu_fetch_req;
  assign wr_accept   = (state_q == PROG) && prog_wr_valid;

  imem_wr_stage #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (wr_accept),
    .addr_i (prog_addr),
    .data_i (prog_data),
    .vld_o  (wr_vld),
    .addr_o (wr_addr),
    .data_o (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RELEASE;
      hold_q      <= HOLD_INIT;
      cnt_q       <= '0;
      fetch_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      fetch_vld_q <= fetch_issue;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (boot_req) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = PROG;
        cnt_d   = '0;
      end
      PROG: begin
        if (wr_accept) cnt_d = sat_inc(cnt_q);
        if (!boot_req) begin
          state_d = RELEASE;
          hold_d  = HOLD_INIT;
        end
      end
      RELEASE: begin
        // A new boot request abandons the hold; the CPU is never released
        if (boot_req) begin
          state_d = DRAIN;
        end else if (hold_q == '0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = RELEASE;
        hold_d  = HOLD_INIT;
      end
    endcase
  end

  assign prog_wr_ready = (state_q == PROG);
  assign cpu_rst_n     = (state_q == RUN);
  assign cpu_stall     = (state_q != RUN);
  assign busy          = (state_q != RUN);
  assign wr_count      = cnt_q;

  // Writes only drain in PROG/first RELEASE cycle, fetches only issue in RUN
  assign mem.mem_we      = wr_vld;
  assign mem.mem_oe      = fetch_issue;
  assign mem.mem_addr    = wr_vld ? wr_addr : (fetch_issue ? cpu_fetch_addr : '0);
  assign mem.mem_wr_data = wr_vld ? wr_data : '0;

  // RAM read data arrives the cycle after the oe cycle, aligned with fetch_vld_q
  assign cpu_fetch_valid = fetch_vld_q;
  assign cpu_fetch_data  = fetch_vld_q ? mem.mem_rd_data : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: behavioural RAM on the slave side, expected memory
// image and session timing kept independently of the design.
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int HOLD  = 4;
  localparam int DEPTH = 16;
  localparam int CMAX  = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, boot_req, prog_wr_valid, prog_wr_ready;
  logic [AW-1:0] prog_addr, cpu_fetch_addr;
  logic [DW-1:0] prog_data, cpu_fetch_data;
  logic          cpu_fetch_req, cpu_fetch_valid, cpu_stall, cpu_rst_n, busy;
  logic [AW:0]   wr_count;

  imem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  imem_port_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .RST_HOLD_CYCLES (HOLD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .boot_req        (boot_req),
    .prog_wr_valid   (prog_wr_valid),
    .prog_wr_ready   (prog_wr_ready),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .cpu_fetch_req   (cpu_fetch_req),
    .cpu_fetch_addr  (cpu_fetch_addr),
    .cpu_fetch_valid (cpu_fetch_valid),
    .cpu_fetch_data  (cpu_fetch_data),
    .cpu_stall       (cpu_stall),
    .cpu_rst_n       (cpu_rst_n),
    .mem             (mif.master),
    .wr_count        (wr_count),
    .busy            (busy)
  );

  // Behavioural single-port RAM (registered read)
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd_q;
  logic          load_ram;
  logic [DW-1:0] exp_mem [DEPTH];

  assign mif.mem_rd_data = rd_q;

  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= exp_mem[i];
      rd_q <= '0;
    end else if (mif.mem_we) begin
      ram[mif.mem_addr] <= mif.mem_wr_data;
    end else if (mif.mem_oe) begin
      rd_q <= ram[mif.mem_addr];
    end
  end

  int n_chk = 0;
  int n_err = 0;
  bit inv_en = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (inv_en) chk_eq("we_oe_excl", 64'(mif.mem_we & mif.mem_oe), 64'(0));
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Called in the first cycle of a release window; returns at the negedge of the first RUN cycle
  task automatic measure_hold(input string tag);
    int  lows  = 0;
    int  guard = 0;
    bit  done  = 1'b0;
    while (!done && guard < 50) begin
      smp();
      if (cpu_rst_n) done = 1'b1;
      else begin
        lows++;
        nxt();
      end
      guard++;
    end
    if (!done) chk_eq({tag, "_timeout"}, 64'(cpu_rst_n), 64'(1));
    chk_eq(tag, 64'(lows), 64'(HOLD));
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input string tag);
    cpu_fetch_req  = 1'b1;
    cpu_fetch_addr = a;
    smp();
    chk_eq({tag, "_oe"}, 64'(mif.mem_oe), 64'(1));
    chk_eq({tag, "_addr"}, 64'(mif.mem_addr), 64'(a));
    nxt();
    cpu_fetch_req = 1'b0;
    smp();
    chk_eq({tag, "_vld"}, 64'(cpu_fetch_valid), 64'(1));
    chk_eq({tag, "_data"}, 64'(cpu_fetch_data), 64'(exp_mem[a]));
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a, prev_addr;
    logic [DW-1:0] d, last_d;
    logic [AW-1:0] last_a;
    logic          prev_req;
    logic [DW-1:0] old7;

    rst_n = 1'b0; boot_req = 1'b0; prog_wr_valid = 1'b0; prog_addr = '0; prog_data = '0;
    cpu_fetch_req = 1'b0; cpu_fetch_addr = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = $urandom;
    exp_mem[9] = 32'hddccbbaa;
    load_ram = 1'b1;
    @(posedge clk);
    #1 load_ram = 1'b0;
    cpu_fetch_req = 1'b1; cpu_fetch_addr = 4'd5;
    nxt();
    smp();
    chk_eq("rst_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
    chk_eq("rst_stall", 64'(cpu_stall), 64'(1));
    chk_eq("rst_busy", 64'(busy), 64'(1));
    chk_eq("rst_we", 64'(mif.mem_we), 64'(0));
    chk_eq("rst_oe", 64'(mif.mem_oe), 64'(0));
    chk_eq("rst_addr", 64'(mif.mem_addr), 64'(0));
    chk_eq("rst_wdata", 64'(mif.mem_wr_data), 64'(0));
    chk_eq("rst_fvld", 64'(cpu_fetch_valid), 64'(0));
    chk_eq("rst_fdata", 64'(cpu_fetch_data), 64'(0));
    chk_eq("rst_ready", 64'(prog_wr_ready), 64'(0));
    chk_eq("rst_wr_count", 64'(wr_count), 64'(0));
    nxt();
    cpu_fetch_req = 1'b0;
    rst_n = 1'b1;
    inv_en = 1'b1;
    measure_hold("hold_after_reset");
    chk_eq("run_stall", 64'(cpu_stall), 64'(0));
    chk_eq("run_busy", 64'(busy), 64'(0));
    nxt();

    // Back-to-back fetches 3 then 4
    cpu_fetch_req = 1'b1; cpu_fetch_addr = 4'd3;
    smp();
    chk_eq("b2b_oe0", 64'(mif.mem_oe), 64'(1));
    chk_eq("b2b_addr0", 64'(mif.mem_addr), 64'(3));
    nxt();
    cpu_fetch_addr = 4'd4;
    smp();
    chk_eq("b2b_vld0", 64'(cpu_fetch_valid), 64'(1));
    chk_eq("b2b_data0", 64'(cpu_fetch_data), 64'(exp_mem[3]));
    chk_eq("b2b_addr1", 64'(mif.mem_addr), 64'(4));
    nxt();
    cpu_fetch_req = 1'b0;
    smp();
    chk_eq("b2b_vld1", 64'(cpu_fetch_valid), 64'(1));
    chk_eq("b2b_data1", 64'(cpu_fetch_data), 64'(exp_mem[4]));
    nxt();
    smp();
    chk_eq("b2b_vld_end", 64'(cpu_fetch_valid), 64'(0));
    nxt();
    do_fetch(4'd9, "preload9");

    // Session 1: boot with a fetch in the same cycle
    boot_req = 1'b1; cpu_fetch_req = 1'b1; cpu_fetch_addr = 4'd5;
    smp();
    chk_eq("s1_fetch_oe", 64'(mif.mem_oe), 64'(1));
    nxt();
    cpu_fetch_addr = 4'd6;
    smp();
    chk_eq("s1_drain_vld", 64'(cpu_fetch_valid), 64'(1));
    chk_eq("s1_drain_data", 64'(cpu_fetch_data), 64'(exp_mem[5]));
    chk_eq("s1_drain_oe", 64'(mif.mem_oe), 64'(0));
    chk_eq("s1_drain_rst", 64'(cpu_rst_n), 64'(0));
    chk_eq("s1_drain_stall", 64'(cpu_stall), 64'(1));
    nxt();
    cpu_fetch_req = 1'b0;
    prog_wr_valid = 1'b1; prog_addr = 4'd9; prog_data = 32'hddccbbaa;
    exp_mem[9] = 32'hddccbbaa;
    smp();
    chk_eq("s1_ready", 64'(prog_wr_ready), 64'(1));
    chk_eq("s1_no_fetch", 64'(cpu_fetch_valid), 64'(0));
    chk_eq("s1_cnt0", 64'(wr_count), 64'(0));
    nxt();
    prog_addr = 4'd15; prog_data = 32'h12345678;
    exp_mem[15] = 32'h12345678;
    smp();
    chk_eq("s1_we0", 64'(mif.mem_we), 64'(1));
    chk_eq("s1_waddr0", 64'(mif.mem_addr), 64'(9));
    chk_eq("s1_wdata0", 64'(mif.mem_wr_data), 64'(32'hddccbbaa));
    chk_eq("s1_cnt1", 64'(wr_count), 64'(1));
    nxt();
    prog_wr_valid = 1'b0;
    smp();
    chk_eq("s1_we1", 64'(mif.mem_we), 64'(1));
    chk_eq("s1_waddr1", 64'(mif.mem_addr), 64'(15));
    chk_eq("s1_wdata1", 64'(mif.mem_wr_data), 64'(32'h12345678));
    chk_eq("s1_cnt2", 64'(wr_count), 64'(2));
    nxt();
    boot_req = 1'b0;
    smp();
    chk_eq("s1_we_idle", 64'(mif.mem_we), 64'(0));
    chk_eq("s1_cnt_hold", 64'(wr_count), 64'(2));
    nxt();
    measure_hold("hold_after_prog");
    nxt();
    do_fetch(4'd15, "s1_fetch15");
    do_fetch(4'd9, "s1_fetch9");

    // Session 2: write on the boot_req-fall cycle, then re-boot mid-release
    boot_req = 1'b1;
    nxt();
    nxt();
    boot_req = 1'b0;
    d = $urandom;
    prog_wr_valid = 1'b1; prog_addr = 4'd2; prog_data = d;
    exp_mem[2] = d;
    smp();
    chk_eq("s2_ready", 64'(prog_wr_ready), 64'(1));
    chk_eq("s2_cnt_cleared", 64'(wr_count), 64'(0));
    nxt();
    prog_addr = 4'd3; prog_data = ~exp_mem[3];
    smp();
    chk_eq("s2_rel_we", 64'(mif.mem_we), 64'(1));
    chk_eq("s2_rel_waddr", 64'(mif.mem_addr), 64'(2));
    chk_eq("s2_rel_wdata", 64'(mif.mem_wr_data), 64'(d));
    chk_eq("s2_rel_ready", 64'(prog_wr_ready), 64'(0));
    chk_eq("s2_rel_rst", 64'(cpu_rst_n), 64'(0));
    nxt();
    prog_wr_valid = 1'b0;
    boot_req = 1'b1;
    smp();
    chk_eq("s2_rel_no_accept", 64'(mif.mem_we), 64'(0));
    chk_eq("s2_rel2_rst", 64'(cpu_rst_n), 64'(0));
    nxt();
    smp();
    chk_eq("s2_drain_rst", 64'(cpu_rst_n), 64'(0));
    chk_eq("s2_drain_ready", 64'(prog_wr_ready), 64'(0));
    nxt();
    smp();
    chk_eq("s2_reprog_ready", 64'(prog_wr_ready), 64'(1));
    chk_eq("s2_reprog_rst", 64'(cpu_rst_n), 64'(0));
    chk_eq("s2_reprog_cnt", 64'(wr_count), 64'(0));
    nxt();

    // 40 writes in the same session: count saturates, last write per address wins
    last_a = '0; last_d = '0;
    for (int k = 0; k < 40; k++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      d = $urandom;
      prog_wr_valid = 1'b1; prog_addr = a; prog_data = d;
      smp();
      chk_eq("sat_cnt", 64'(wr_count), 64'((k < CMAX) ? k : CMAX));
      chk_eq("sat_we", 64'(mif.mem_we), 64'(k > 0));
      if (k > 0) begin
        chk_eq("sat_waddr", 64'(mif.mem_addr), 64'(last_a));
        chk_eq("sat_wdata", 64'(mif.mem_wr_data), 64'(last_d));
      end
      exp_mem[a] = d;
      last_a = a; last_d = d;
      nxt();
    end
    prog_wr_valid = 1'b0;
    smp();
    chk_eq("sat_cnt_final", 64'(wr_count), 64'(CMAX));
    chk_eq("sat_last_waddr", 64'(mif.mem_addr), 64'(last_a));
    nxt();
    boot_req = 1'b0;
    smp();
    chk_eq("sat_cnt_stay", 64'(wr_count), 64'(CMAX));
    nxt();
    measure_hold("hold_after_bulk");
    nxt();
    for (int i = 0; i < DEPTH; i++) do_fetch(AW'(i), "image");

    // Random fetch stream: one result per issued fetch, one cycle later
    prev_req = 1'b0; prev_addr = '0;
    for (int k = 0; k < 30; k++) begin
      cpu_fetch_req  = 1'($urandom_range(0, 1));
      cpu_fetch_addr = AW'($urandom_range(0, DEPTH - 1));
      smp();
      chk_eq("rnd_vld", 64'(cpu_fetch_valid), 64'(prev_req));
      if (prev_req) chk_eq("rnd_data", 64'(cpu_fetch_data), 64'(exp_mem[prev_addr]));
      chk_eq("rnd_oe", 64'(mif.mem_oe), 64'(cpu_fetch_req));
      prev_req = cpu_fetch_req; prev_addr = cpu_fetch_addr;
      nxt();
    end
    cpu_fetch_req = 1'b0;
    smp();
    chk_eq("rnd_vld_last", 64'(cpu_fetch_valid), 64'(prev_req));
    if (prev_req) chk_eq("rnd_data_last", 64'(cpu_fetch_data), 64'(exp_mem[prev_addr]));
    nxt();

    // Programmer write while the CPU runs is ignored
    prog_wr_valid = 1'b1; prog_addr = 4'd6; prog_data = ~exp_mem[6];
    smp();
    chk_eq("run_ready", 64'(prog_wr_ready), 64'(0));
    nxt();
    prog_wr_valid = 1'b0;
    smp();
    chk_eq("run_no_we", 64'(mif.mem_we), 64'(0));
    nxt();
    do_fetch(4'd6, "run_unchanged6");

    // Reset with a write pending in the write stage
    old7 = exp_mem[7];
    boot_req = 1'b1;
    nxt();
    nxt();
    prog_wr_valid = 1'b1; prog_addr = 4'd7; prog_data = ~old7;
    nxt();
    prog_wr_valid = 1'b0;
    smp();
    chk_eq("pend_we", 64'(mif.mem_we), 64'(1));
    rst_n = 1'b0;
    boot_req = 1'b0;
    #1;
    chk_eq("pend_rst_we", 64'(mif.mem_we), 64'(0));
    chk_eq("pend_rst_addr", 64'(mif.mem_addr), 64'(0));
    chk_eq("pend_rst_cpu", 64'(cpu_rst_n), 64'(0));
    chk_eq("pend_rst_cnt", 64'(wr_count), 64'(0));
    nxt();
    nxt();
    rst_n = 1'b1;
    measure_hold("hold_after_rst2");
    nxt();
    do_fetch(4'd7, "pend_lost7");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
